// File: rtl/mul32_pkg.sv
// rtl/mul32_pkg.sv - op encodings, state type and operand helper shared by the mul32 block
package mul32_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mul_state_t;

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_digit_pp.sv
// rtl/mul_digit_pp.sv - combinational magnitude times one multiplier digit
module mul_digit_pp #(
    parameter int RADIX_BITS = 4
) (
    input  logic [31:0]              a,
    input  logic [RADIX_BITS-1:0]    digit,
    output logic [32+RADIX_BITS-1:0] pp
);

    localparam int PP_W = 32 + RADIX_BITS;

    assign pp = {{RADIX_BITS{1'b0}}, a} * {{32{1'b0}}, digit};

endmodule

// File: rtl/mul32.sv
// rtl/mul32.sv - iterative radix-2^RADIX_BITS RV32M multiplier; MUL32_EARLY_OUT_EN enables early exit
module mul32
    import mul32_pkg::*;
#(
    parameter int RADIX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    localparam int ITER  = 32 / RADIX_BITS;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int PP_W  = 32 + RADIX_BITS;

    mul_state_t            state;
    mul_op_t               op_q;
    logic                  sign_a;
    logic                  sign_b;
    logic [31:0]           a_abs;
    logic [31:0]           b_rem;
    logic [63:0]           acc;
    logic [5:0]            sh;
    logic [CNT_W-1:0]      count;

    logic                  a_signed;
    logic                  b_signed;
    logic [RADIX_BITS-1:0] digit;
    logic [PP_W-1:0]       pp;
    logic [63:0]           acc_next;
    logic [31:0]           b_next;
    logic                  last_step;
    logic [63:0]           prod;

    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU);
    assign b_signed = (op == OP_MULH);
    assign digit    = b_rem[RADIX_BITS-1:0];
    assign b_next   = b_rem >> RADIX_BITS;

    mul_digit_pp #(.RADIX_BITS(RADIX_BITS)) u_pp (
        .a     (a_abs),
        .digit (digit),
        .pp    (pp)
    );

    assign acc_next = acc + ({{(64-PP_W){1'b0}}, pp} << sh);

`ifdef MUL32_EARLY_OUT_EN
    // Once the remaining multiplier digits are all zero, later steps add nothing.
    assign last_step = (count == CNT_W'(1)) || (b_next == 32'd0);
`else
    assign last_step = (count == CNT_W'(1));
`endif

    // sign flags are only ever set for signed ops, so MUL/MULHU never negate
    assign prod = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_MUL;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_abs  <= 32'd0;
            b_rem  <= 32'd0;
            acc    <= 64'd0;
            sh     <= 6'd0;
            count  <= '0;
            result <= 32'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q   <= mul_op_t'(op);
                        sign_a <= a_signed & rs1[31];
                        sign_b <= b_signed & rs2[31];
                        a_abs  <= abs32(rs1, a_signed);
                        b_rem  <= abs32(rs2, b_signed);
                        acc    <= 64'd0;
                        sh     <= 6'd0;
                        count  <= CNT_W'(ITER);
                        busy   <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc   <= acc_next;
                    b_rem <= b_next;
                    sh    <= sh + 6'(RADIX_BITS);
                    count <= count - CNT_W'(1);
                    if (last_step) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result <= (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
